// File: rtl/tb_mem_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between the instruction and
// data ports, with one-cycle response routing and saturating stall counters.
module tb_mem_arbiter #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  instr_req_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,

    input  logic                  data_req_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [DATA_WIDTH-1:0] data_rdata_o,

    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,

    output logic [CNT_WIDTH-1:0]  instr_stall_cnt_o,
    output logic [CNT_WIDTH-1:0]  data_stall_cnt_o,
    input  logic                  cnt_clr_i
);

    typedef enum logic [1:0] {
        OWN_IDLE  = 2'd0,
        OWN_INSTR = 2'd1,
        OWN_DATA  = 2'd2
    } owner_t;

    owner_t                 r_owner;
    owner_t                 w_ownerNext;
    logic                   r_prio;
    logic                   w_instrGnt;
    logic                   w_dataGnt;
    logic [CNT_WIDTH-1:0]   r_instrStallCnt;
    logic [CNT_WIDTH-1:0]   r_dataStallCnt;

    // r_prio = 1 means instr wins a tie; grants are suppressed while in reset
    always_comb begin
        w_instrGnt = 1'b0;
        w_dataGnt  = 1'b0;
        if (rst_ni) begin
            if (instr_req_i && (!data_req_i || r_prio)) begin
                w_instrGnt = 1'b1;
            end else if (data_req_i) begin
                w_dataGnt = 1'b1;
            end
        end
    end

    assign instr_gnt_o = w_instrGnt;
    assign data_gnt_o  = w_dataGnt;
    assign mem_req_o   = w_instrGnt | w_dataGnt;
    assign mem_addr_o  = w_instrGnt ? instr_addr_i : data_addr_i;
    assign mem_we_o    = w_dataGnt & data_we_i;
    assign mem_be_o    = w_instrGnt ? 4'hF : data_be_i;
    assign mem_wdata_o = data_wdata_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_prio <= 1'b0;
        end else if (w_dataGnt) begin
            r_prio <= 1'b1;
        end else if (w_instrGnt) begin
            r_prio <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_owner <= OWN_IDLE;
        end else begin
            r_owner <= w_ownerNext;
        end
    end

    // A response owed across a reset assertion is dropped, hence the rst_ni gating
    always_comb begin
        w_ownerNext    = OWN_IDLE;
        instr_rvalid_o = 1'b0;
        data_rvalid_o  = 1'b0;
        if (w_instrGnt) begin
            w_ownerNext = OWN_INSTR;
        end else if (w_dataGnt) begin
            w_ownerNext = OWN_DATA;
        end
        case (r_owner)
            OWN_INSTR: instr_rvalid_o = rst_ni;
            OWN_DATA:  data_rvalid_o  = rst_ni;
            default: ;
        endcase
    end

    assign instr_rdata_o = mem_rdata_i;
    assign data_rdata_o  = mem_rdata_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || cnt_clr_i) begin
            r_instrStallCnt <= '0;
            r_dataStallCnt  <= '0;
        end else begin
            if (instr_req_i && !w_instrGnt && (r_instrStallCnt != '1)) begin
                r_instrStallCnt <= r_instrStallCnt + CNT_WIDTH'(1);
            end
            if (data_req_i && !w_dataGnt && (r_dataStallCnt != '1)) begin
                r_dataStallCnt <= r_dataStallCnt + CNT_WIDTH'(1);
            end
        end
    end

    assign instr_stall_cnt_o = r_instrStallCnt;
    assign data_stall_cnt_o  = r_dataStallCnt;

endmodule

// File: tb/tb_tb_mem_arbiter.sv
// Self-checking bench for tb_mem_arbiter: directed scenarios followed by random
// traffic, compared against a transaction-level model of arbitration and SRAM.
module tb_tb_mem_arbiter;

    localparam int AW     = 20;
    localparam int DW     = 32;
    localparam int CW     = 4;
    localparam int CNTMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rstN;
    logic          instrReq;
    logic [AW-1:0] instrAddr;
    logic          instrGnt;
    logic          instrRvalid;
    logic [DW-1:0] instrRdata;
    logic          dataReq;
    logic [AW-1:0] dataAddr;
    logic          dataWe;
    logic [3:0]    dataBe;
    logic [DW-1:0] dataWdata;
    logic          dataGnt;
    logic          dataRvalid;
    logic [DW-1:0] dataRdata;
    logic          memReq;
    logic [AW-1:0] memAddr;
    logic          memWe;
    logic [3:0]    memBe;
    logic [DW-1:0] memWdata;
    logic [DW-1:0] memRdata;
    logic [CW-1:0] instrStallCnt;
    logic [CW-1:0] dataStallCnt;
    logic          cntClr;

    logic [DW-1:0] sram   [0:2047];
    logic [DW-1:0] refMem [0:2047];

    int   vectors     = 0;
    int   miscompares = 0;

    // Model state: who wins a tie, what response is owed next cycle, stall counts
    bit            instrPref;
    int            owedPort;
    logic [DW-1:0] owedData;
    bit            owedRead;
    int            iCnt;
    int            dCnt;
    bit            expI;
    bit            expD;

    always #5 clk = ~clk;

    tb_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_ni(rstN),
        .instr_req_i(instrReq), .instr_addr_i(instrAddr), .instr_gnt_o(instrGnt),
        .instr_rvalid_o(instrRvalid), .instr_rdata_o(instrRdata),
        .data_req_i(dataReq), .data_addr_i(dataAddr), .data_we_i(dataWe),
        .data_be_i(dataBe), .data_wdata_i(dataWdata), .data_gnt_o(dataGnt),
        .data_rvalid_o(dataRvalid), .data_rdata_o(dataRdata),
        .mem_req_o(memReq), .mem_addr_o(memAddr), .mem_we_o(memWe), .mem_be_o(memBe),
        .mem_wdata_o(memWdata), .mem_rdata_i(memRdata),
        .instr_stall_cnt_o(instrStallCnt), .data_stall_cnt_o(dataStallCnt),
        .cnt_clr_i(cntClr)
    );

    function automatic logic [DW-1:0] mergeBytes(input logic [DW-1:0] oldW,
                                                 input logic [DW-1:0] newW,
                                                 input logic [3:0] be);
        logic [DW-1:0] res;
        res = oldW;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = newW[8*b +: 8];
        end
        return res;
    endfunction

    always @(posedge clk) begin
        if (memReq) begin
            if (memWe) sram[memAddr[12:2]] <= mergeBytes(sram[memAddr[12:2]], memWdata, memBe);
            else       memRdata <= sram[memAddr[12:2]];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the currently driven inputs: predict, check mid-cycle, advance model
    task automatic applyStimulus();
        int ownNow;
        expI   = rstN && instrReq && (!dataReq || instrPref);
        expD   = rstN && dataReq && !expI;
        ownNow = rstN ? owedPort : 0;
        @(negedge clk);
        checkOutput("instr_gnt", 32'(instrGnt), 32'(expI));
        checkOutput("data_gnt", 32'(dataGnt), 32'(expD));
        checkOutput("mem_req", 32'(memReq), 32'(expI | expD));
        checkOutput("mem_we", 32'(memWe), 32'(expD && dataWe));
        if (expI) begin
            checkOutput("mem_addr_i", 32'(memAddr), 32'(instrAddr));
            checkOutput("mem_be_i", 32'(memBe), 32'hF);
        end
        if (expD) begin
            checkOutput("mem_addr_d", 32'(memAddr), 32'(dataAddr));
            checkOutput("mem_be_d", 32'(memBe), 32'(dataBe));
            if (dataWe) checkOutput("mem_wdata", memWdata, dataWdata);
        end
        checkOutput("instr_rvalid", 32'(instrRvalid), 32'(ownNow == 1));
        checkOutput("data_rvalid", 32'(dataRvalid), 32'(ownNow == 2));
        if (ownNow == 1) checkOutput("instr_rdata", instrRdata, owedData);
        if (ownNow == 2 && owedRead) checkOutput("data_rdata", dataRdata, owedData);
        checkOutput("instr_stall_cnt", 32'(instrStallCnt), 32'(iCnt));
        checkOutput("data_stall_cnt", 32'(dataStallCnt), 32'(dCnt));
        @(posedge clk);
        if (!rstN) begin
            instrPref = 0;
            owedPort  = 0;
            iCnt      = 0;
            dCnt      = 0;
        end else begin
            if (cntClr) begin
                iCnt = 0;
                dCnt = 0;
            end else begin
                if (instrReq && !expI) iCnt = (iCnt < CNTMAX) ? iCnt + 1 : CNTMAX;
                if (dataReq && !expD)  dCnt = (dCnt < CNTMAX) ? dCnt + 1 : CNTMAX;
            end
            owedPort = expI ? 1 : (expD ? 2 : 0);
            if (expI) begin
                owedData = refMem[instrAddr[12:2]];
                owedRead = 1;
            end
            if (expD) begin
                if (dataWe) begin
                    refMem[dataAddr[12:2]] = mergeBytes(refMem[dataAddr[12:2]], dataWdata, dataBe);
                    owedRead = 0;
                end else begin
                    owedData = refMem[dataAddr[12:2]];
                    owedRead = 1;
                end
            end
            if (expD)      instrPref = 1;
            else if (expI) instrPref = 0;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            sram[i]   = 32'(i) * 32'h9E3779B1;
            refMem[i] = 32'(i) * 32'h9E3779B1;
        end
        memRdata  = '0;
        rstN      = 1'b0;
        instrReq  = 1'b0;
        instrAddr = '0;
        dataReq   = 1'b0;
        dataAddr  = '0;
        dataWe    = 1'b0;
        dataBe    = 4'h0;
        dataWdata = '0;
        cntClr    = 1'b0;
        instrPref = 0;
        owedPort  = 0;
        owedData  = '0;
        owedRead  = 0;
        iCnt      = 0;
        dCnt      = 0;
        @(posedge clk);
        #1;

        // Reset: a pending write request must not reach the SRAM
        applyStimulus();
        dataReq   = 1'b1;
        dataWe    = 1'b1;
        dataBe    = 4'hF;
        dataAddr  = 20'h00800;
        dataWdata = 32'h12345678;
        applyStimulus();

        // Continuous contention from the first cycle out of reset: D,I,D,I,D,I
        rstN      = 1'b1;
        dataWe    = 1'b0;
        dataAddr  = 20'h00200;
        instrReq  = 1'b1;
        instrAddr = 20'h00100;
        for (int c = 0; c < 6; c++) applyStimulus();
        checkOutput("contention_icnt", 32'(instrStallCnt), 32'd3);
        checkOutput("contention_dcnt", 32'(dataStallCnt), 32'd3);

        // Instruction fetch stream, uncontended
        dataReq = 1'b0;
        cntClr  = 1'b1;
        instrReq = 1'b0;
        applyStimulus();
        cntClr  = 1'b0;
        instrReq = 1'b1;
        for (int c = 0; c < 3; c++) begin
            instrAddr = AW'(32'h180 + 32'(4 * c));
            applyStimulus();
        end
        instrReq = 1'b0;
        applyStimulus();

        // Partial write then read-back of the same word
        dataReq   = 1'b1;
        dataWe    = 1'b1;
        dataBe    = 4'b0011;
        dataAddr  = 20'h01000;
        dataWdata = 32'hDEADBEEF;
        applyStimulus();
        dataWe    = 1'b0;
        applyStimulus();
        dataReq   = 1'b0;
        applyStimulus();
        checkOutput("partial_write", refMem[20'h01000 >> 2], {sram[20'h01000 >> 2][31:16], 16'hBEEF});

        // Reset right after an instr grant drops the owed response
        instrReq  = 1'b1;
        instrAddr = 20'h00040;
        applyStimulus();
        instrReq  = 1'b0;
        rstN      = 1'b0;
        applyStimulus();
        rstN      = 1'b1;
        applyStimulus();
        instrReq  = 1'b1;
        dataReq   = 1'b1;
        applyStimulus();

        // Stall counter saturation and clear overriding a simultaneous stall
        for (int c = 0; c < 34; c++) applyStimulus();
        checkOutput("icnt_saturated", 32'(instrStallCnt), CNTMAX);
        while (instrPref) applyStimulus();
        cntClr = 1'b1;
        applyStimulus();
        cntClr = 1'b0;
        applyStimulus();

        // Data-only burst leaves instr preferred once contention starts
        instrReq = 1'b0;
        for (int c = 0; c < 4; c++) begin
            dataAddr = AW'(32'h300 + 32'(4 * c));
            applyStimulus();
        end
        instrReq = 1'b1;
        applyStimulus();
        instrReq = 1'b0;
        dataReq  = 1'b0;
        applyStimulus();

        // Random traffic; each requester holds its request until the model grants it
        for (int c = 0; c < 400; c++) begin
            if (!instrReq || expI) begin
                instrReq  = ($urandom_range(0, 3) != 0);
                instrAddr = AW'(32'($urandom_range(0, 2047)) << 2);
            end
            if (!dataReq || expD) begin
                dataReq   = ($urandom_range(0, 3) != 0);
                dataAddr  = AW'(32'($urandom_range(0, 2047)) << 2);
                dataWe    = 1'($urandom_range(0, 1));
                dataBe    = 4'($urandom);
                dataWdata = $urandom;
            end
            cntClr = ($urandom_range(0, 19) == 0);
            rstN   = ($urandom_range(0, 49) != 0);
            applyStimulus();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
